// File: rtl/rv32i_fetch_pkg.sv
// rv32i_fetch_pkg: shared types and constants for the rv32i instruction fetch unit
package rv32i_fetch_pkg;

    typedef enum logic {RUN, DRAIN} fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// rv32i_fetch_fifo: synchronous queue of fetch entries with flush and a registered head entry
module rv32i_fetch_fifo
    import rv32i_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t head_q, head_d;

    // Write at the tail, advance on pop, flush empties; head is preloaded from the next-state storage
    always_comb begin
        mem_d = mem_q;
        if (push && !flush) mem_d[wr_q] = push_data;
        rd_d = flush ? '0 : rd_q + AW'(pop);
        wr_d = flush ? '0 : wr_q + AW'(push);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        head_d = mem_d[rd_d];
    end

    // Storage, pointers and head register; reset clears contents so outputs read zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
            head_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
            head_q <= head_d;
        end
    end

    assign count = count_q;
    assign head = head_q;

endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: request/response instruction fetch with a prefetch queue and redirect flush.
// Defining RV32I_FETCH_PERF_EN adds saturating stall and flush performance counters.
module rv32i_fetch
    import rv32i_fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef RV32I_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CW-1:0] out_q, out_d, count;
    logic req_fire, push, pop, credit;
    fetch_entry_t push_entry, head;

    assign target = {redirect_pc[31:2], 2'b00};
    assign credit = (out_q + count) < DEPTH_C;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign instr_valid = count != '0;
    assign instr = head.instr;
    assign instr_pc = head.pc;

    // Issue credit, in-flight tracking and RUN/DRAIN transitions; stale responses are dropped while draining
    always_comb begin
        imem_req_valid = rst_n && state_q == RUN && credit && !redirect_valid;
        imem_req_addr = fetch_pc_q;
        req_fire = imem_req_valid && imem_req_ready;
        push = state_q == RUN && imem_rsp_valid && !redirect_valid;
        pop = instr_valid && instr_ready;
        out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        fetch_pc_d = redirect_valid ? target : req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
        rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + PC_STEP : rsp_pc_q;
        state_d = (redirect_valid || state_q == DRAIN) ? (out_d != '0 ? DRAIN : RUN) : RUN;
    end

    // Fetch state and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q <= out_d;
        end
    end

    rv32i_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    // A response with nothing outstanding means the memory broke the protocol
    assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && out_q == '0));

`ifdef RV32I_FETCH_PERF_EN
    logic [31:0] stall_q, stall_d, flush_q, flush_d;

    // Saturating counters for decode starvation cycles and redirects
    always_comb begin
        stall_d = stall_q + 32'(instr_ready && !instr_valid && stall_q != '1);
        flush_d = flush_q + 32'(redirect_valid && flush_q != '1);
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`endif

endmodule
